// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MIPS memory stage: big-endian byte enables,
// link-state encodings and the EX/MEM pipeline register layout.
package mem_stage_pkg;

    localparam logic [3:0] BE_B0   = 4'b1000;
    localparam logic [3:0] BE_B1   = 4'b0100;
    localparam logic [3:0] BE_B2   = 4'b0010;
    localparam logic [3:0] BE_B3   = 4'b0001;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    typedef enum logic [0:0] {
        LINK_NONE = 1'b0,
        LINK_HELD = 1'b1
    } link_state_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic        reg_we;
        logic [4:0]  reg_write_addr;
        logic        mem_read;
        logic        mem_byte;
        logic        mem_signextend;
        logic        sc;
        logic        sc_ok;
    } ex_mem_t;

    // Byte 0 lives in the most significant lane (big-endian).
    function automatic logic [3:0] byte_lane_be(input logic [1:0] addr_lo);
        logic [3:0] be;
        case (addr_lo)
            2'd0:    be = BE_B0;
            2'd1:    be = BE_B1;
            2'd2:    be = BE_B2;
            2'd3:    be = BE_B3;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed big-endian byte lane and zero- or
// sign-extends it, or passes the full word through.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        is_byte,
    input  logic        sign_extend,
    output logic [31:0] load_data
);

    logic [7:0] lane_s;

    // Byte-lane select and extension
    always_comb begin
        lane_s = rdata[31:24];
        case (addr_lo)
            2'd0:    lane_s = rdata[31:24];
            2'd1:    lane_s = rdata[23:16];
            2'd2:    lane_s = rdata[15:8];
            2'd3:    lane_s = rdata[7:0];
            default: lane_s = rdata[31:24];
        endcase
        if (is_byte) begin
            load_data = {{24{sign_extend & lane_s[7]}}, lane_s};
        end else begin
            load_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data-memory request, EX/MEM register, load formatting and
// LL/SC reservation. Optional feature macro: MEM_STAGE_LLSC_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_ex,
    input  logic [31:0] mem_write_data_ex,
    input  logic        mem_we_ex,
    input  logic        mem_read_ex,
    input  logic        mem_byte_ex,
    input  logic        mem_signextend_ex,
    input  logic        mem_ll_ex,
    input  logic        mem_sc_ex,
    input  logic        reg_we_ex,
    input  logic [4:0]  reg_write_addr_ex,
    output logic [31:0] dmem_addr,
    output logic        dmem_re,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        reg_we_mem,
    output logic [4:0]  reg_write_addr_mem,
    output logic [31:0] reg_write_data_mem,
    output logic        link_valid
);

    logic        sc_ok_s;
    ex_mem_t     ex_mem_r;
    logic [31:0] load_data_s;

`ifdef MEM_STAGE_LLSC_EN
    link_state_e state_r;
    link_state_e state_next_s;
    logic [29:0] link_addr_r;
    logic        link_hit_s;

    assign link_hit_s = (link_addr_r == alu_result_ex[31:2]);
    assign sc_ok_s    = (state_r == LINK_HELD) && link_hit_s;

    // Link state and reservation address register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= LINK_NONE;
            link_addr_r <= 30'd0;
        end else begin
            state_r <= state_next_s;
            if (mem_ll_ex && !mem_sc_ex) begin
                link_addr_r <= alu_result_ex[31:2];
            end
        end
    end

    // Next link state; SC beats LL beats a clearing store
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LINK_NONE: begin
                if (mem_sc_ex) begin
                    state_next_s = LINK_NONE;
                end else if (mem_ll_ex) begin
                    state_next_s = LINK_HELD;
                end else begin
                    state_next_s = LINK_NONE;
                end
            end
            LINK_HELD: begin
                if (mem_sc_ex) begin
                    state_next_s = LINK_NONE;
                end else if (mem_ll_ex) begin
                    state_next_s = LINK_HELD;
                end else if (mem_we_ex && link_hit_s) begin
                    state_next_s = LINK_NONE;
                end else begin
                    state_next_s = LINK_HELD;
                end
            end
            default: state_next_s = LINK_NONE;
        endcase
    end

    // Link output decode
    always_comb begin
        link_valid = (state_r == LINK_HELD);
    end
`else
    logic unused_ll_s;

    // Without reservations LL is an ordinary load and every SC succeeds.
    assign unused_ll_s = mem_ll_ex;
    assign sc_ok_s     = 1'b1;
    assign link_valid  = 1'b0;
`endif

    assign dmem_addr = {alu_result_ex[31:2], 2'b00};
    assign dmem_re   = mem_read_ex;

    // Store byte enables and lane-replicated write data
    always_comb begin
        dmem_be    = BE_NONE;
        dmem_wdata = mem_write_data_ex;
        if (mem_we_ex) begin
            if (mem_byte_ex) begin
                dmem_be    = byte_lane_be(alu_result_ex[1:0]);
                dmem_wdata = {4{mem_write_data_ex[7:0]}};
            end else if (!mem_sc_ex || sc_ok_s) begin
                dmem_be = BE_WORD;
            end else begin
                dmem_be = BE_NONE;
            end
        end else begin
            dmem_be = BE_NONE;
        end
    end

    // EX/MEM pipeline register, captured every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_r <= '0;
        end else begin
            ex_mem_r.alu_result     <= alu_result_ex;
            ex_mem_r.reg_we         <= reg_we_ex;
            ex_mem_r.reg_write_addr <= reg_write_addr_ex;
            ex_mem_r.mem_read       <= mem_read_ex;
            ex_mem_r.mem_byte       <= mem_byte_ex;
            ex_mem_r.mem_signextend <= mem_signextend_ex;
            ex_mem_r.sc             <= mem_sc_ex;
            ex_mem_r.sc_ok          <= sc_ok_s;
        end
    end

    mem_load_align u_load_align (
        .rdata       (dmem_rdata),
        .addr_lo     (ex_mem_r.alu_result[1:0]),
        .is_byte     (ex_mem_r.mem_byte),
        .sign_extend (ex_mem_r.mem_signextend),
        .load_data   (load_data_s)
    );

    assign reg_we_mem         = ex_mem_r.reg_we;
    assign reg_write_addr_mem = ex_mem_r.reg_write_addr;

    // Writeback/forward value select
    always_comb begin
        if (ex_mem_r.sc) begin
            reg_write_data_mem = {31'd0, ex_mem_r.sc_ok};
        end else if (ex_mem_r.mem_read) begin
            reg_write_data_mem = load_data_s;
        end else begin
            reg_write_data_mem = ex_mem_r.alu_result;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations adapt to MEM_STAGE_LLSC_EN.
module tb_mem_stage;

`ifdef MEM_STAGE_LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result_ex, mem_write_data_ex, dmem_rdata;
    logic        mem_we_ex, mem_read_ex, mem_byte_ex, mem_signextend_ex;
    logic        mem_ll_ex, mem_sc_ex, reg_we_ex;
    logic [4:0]  reg_write_addr_ex;
    logic [31:0] dmem_addr, dmem_wdata, reg_write_data_mem;
    logic        dmem_re, reg_we_mem, link_valid;
    logic [3:0]  dmem_be;
    logic [4:0]  reg_write_addr_mem;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .alu_result_ex(alu_result_ex), .mem_write_data_ex(mem_write_data_ex),
        .mem_we_ex(mem_we_ex), .mem_read_ex(mem_read_ex), .mem_byte_ex(mem_byte_ex),
        .mem_signextend_ex(mem_signextend_ex), .mem_ll_ex(mem_ll_ex), .mem_sc_ex(mem_sc_ex),
        .reg_we_ex(reg_we_ex), .reg_write_addr_ex(reg_write_addr_ex),
        .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .reg_we_mem(reg_we_mem), .reg_write_addr_mem(reg_write_addr_mem),
        .reg_write_data_mem(reg_write_data_mem), .link_valid(link_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic rd, input logic bt, input logic sx,
                         input logic ll, input logic sc, input logic [31:0] addr,
                         input logic [31:0] data, input logic rwe, input logic [4:0] rwa);
        mem_we_ex = we; mem_read_ex = rd; mem_byte_ex = bt; mem_signextend_ex = sx;
        mem_ll_ex = ll; mem_sc_ex = sc; alu_result_ex = addr; mem_write_data_ex = data;
        reg_we_ex = rwe; reg_write_addr_ex = rwa;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'd0, 1'b1, 5'd3);
        tick();
        tick();
        check("rst_reg_we", {31'd0, reg_we_mem}, 32'd0);
        check("rst_waddr", {27'd0, reg_write_addr_mem}, 32'd0);
        check("rst_wdata", reg_write_data_mem, 32'd0);
        check("rst_link", {31'd0, link_valid}, 32'd0);
        check("dmem_re", {31'd0, dmem_re}, 32'd1);
        rst = 1'b0;

        // SB lanes
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0102, 32'h0000_00A5, 1'b0, 5'd0);
        check("sb2_be", {28'd0, dmem_be}, 32'h2);
        check("sb2_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("sb2_addr", dmem_addr, 32'h0000_0100);
        tick();
        check("sb2_mem_data", reg_write_data_mem, 32'h0000_0102);
        check("sb2_mem_we", {31'd0, reg_we_mem}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0013, 1'b0, 5'd0);
        check("sb0_be", {28'd0, dmem_be}, 32'h8);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0103, 32'h0000_0013, 1'b0, 5'd0);
        check("sb3_be", {28'd0, dmem_be}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 32'h1234_5678, 1'b0, 5'd0);
        check("sw_be", {28'd0, dmem_be}, 32'hF);
        check("sw_wdata", dmem_wdata, 32'h1234_5678);
        check("sw_addr", dmem_addr, 32'h0000_0004);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h1234_5678, 1'b1, 5'd2);
        check("load_be", {28'd0, dmem_be}, 32'h0);

        // Loads
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0201, 32'd0, 1'b1, 5'd5);
        tick();
        dmem_rdata = 32'h11F2_3344;
        #1;
        check("lb_data", reg_write_data_mem, 32'hFFFF_FFF2);
        check("lb_we", {31'd0, reg_we_mem}, 32'd1);
        check("lb_waddr", {27'd0, reg_write_addr_mem}, 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0201, 32'd0, 1'b1, 5'd6);
        tick();
        check("lbu_data", reg_write_data_mem, 32'h0000_00F2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0203, 32'd0, 1'b1, 5'd6);
        tick();
        check("lb3_data", reg_write_data_mem, 32'h0000_0044);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'd0, 1'b1, 5'd6);
        tick();
        check("lbu0_data", reg_write_data_mem, 32'h0000_0011);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0203, 32'd0, 1'b1, 5'd7);
        tick();
        check("lw_data", reg_write_data_mem, 32'h11F2_3344);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 5'd9);
        tick();
        check("alu_data", reg_write_data_mem, 32'hDEAD_BEEF);
        check("alu_waddr", {27'd0, reg_write_addr_mem}, 32'd9);

        // LL then SC to the same word
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 1'b1, 5'd8);
        tick();
        check("ll_link", {31'd0, link_valid}, {31'd0, LLSC});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'd7, 1'b1, 5'd8);
        check("sc_ok_be", {28'd0, dmem_be}, 32'hF);
        tick();
        check("sc_ok_data", reg_write_data_mem, 32'd1);
        check("sc_ok_link", {31'd0, link_valid}, 32'd0);

        // Intervening store to the linked word
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 1'b1, 5'd8);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'd3, 1'b0, 5'd0);
        tick();
        check("sw_clr_link", {31'd0, link_valid}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'd7, 1'b1, 5'd8);
        check("sc_clr_be", {28'd0, dmem_be}, LLSC ? 32'h0 : 32'hF);
        tick();
        check("sc_clr_data", reg_write_data_mem, LLSC ? 32'd0 : 32'd1);

        // Store to another word keeps the link; SC in same cycle clears it
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'd0, 1'b1, 5'd4);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0504, 32'd3, 1'b0, 5'd0);
        tick();
        check("sw_other_link", {31'd0, link_valid}, {31'd0, LLSC});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'd9, 1'b1, 5'd4);
        check("sc500_be", {28'd0, dmem_be}, 32'hF);
        tick();
        check("sc500_data", reg_write_data_mem, 32'd1);
        check("sc500_link", {31'd0, link_valid}, 32'd0);

        // SC with no reservation
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'd9, 1'b1, 5'd4);
        check("sc_nolink_be", {28'd0, dmem_be}, LLSC ? 32'h0 : 32'hF);
        tick();
        check("sc_nolink_data", reg_write_data_mem, LLSC ? 32'd0 : 32'd1);

        // Reset mid-operation drops the reservation and the in-flight op
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 32'd0, 1'b1, 5'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_link", {31'd0, link_valid}, 32'd0);
        check("rst_mid_we", {31'd0, reg_we_mem}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 32'd1, 1'b1, 5'd10);
        check("rst_mid_sc_be", {28'd0, dmem_be}, LLSC ? 32'h0 : 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
